seq_detect_prog: RTL and testbench

- Parametrised, runtime-programmable serial sequence detector. Successor to the fixed 4-bit Moore pattern detectors in the FSM library.
- Samples one serial bit per qualified cycle and compares the most recent bits against a programmable pattern of 1..MAX_LEN bits.
- Moore-style registered match pulse. Overlapping and non-overlapping detection are selectable at runtime.
- Sits between a serial front end (deserialiser / line decoder) and control logic needing frame or sync-word flags.

---
 rtl/seq_detect_prog.sv | 175 +++++++++++++++++
 tb/tb_seq_detect_prog.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial sequence detector with a registered Moore match pulse.
// Define SEQ_DETECT_MATCH_COUNT_EN to add the saturating match counter (match_count, cnt_clear).
module seq_detect_prog #(
    parameter int                 MAX_LEN         = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_1101),
    parameter int                 DEFAULT_LEN     = 4,
    parameter int                 CNT_W           = 16,
    localparam int                LEN_W           = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    input  logic               cnt_clear,
    output logic [CNT_W-1:0]   match_count,
`endif
    output logic               dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE_C = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_DEF_C = LEN_W'(DEFAULT_LEN);

    if (MAX_LEN < 2 || CNT_W < 1 || DEFAULT_LEN < 1 || DEFAULT_LEN > MAX_LEN) begin : g_param_check
        $error("seq_detect_prog: illegal parameter combination");
    end

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               dout_q, dout_d;

    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   cfg_len_clamped;
    logic               pattern_hit;
    logic               armed_next;
    logic               match;

    // Only the low len_q bits of history take part in the comparison.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_len_mask
        assign len_mask[gi] = (gi < int'(len_q));
    end

    always_comb begin
        cfg_len_clamped = cfg_len;
        if (cfg_len == '0) begin
            cfg_len_clamped = LEN_ONE_C;
        end else if (cfg_len > LEN_MAX_C) begin
            cfg_len_clamped = LEN_MAX_C;
        end
    end

    // Post-shift view of history and fill; the match is judged on these.
    always_comb begin
        hist_shift  = {hist_q[MAX_LEN-2:0], din};
        fill_shift  = (fill_q == LEN_MAX_C) ? fill_q : fill_q + LEN_ONE_C;
        pattern_hit = ((hist_shift ^ pat_q) & len_mask) == '0;
        armed_next  = (fill_shift >= len_q);
        match       = din_valid && !cfg_we && pattern_hit && armed_next;
    end

    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        dout_d    = match;
        state_d   = state_q;

        if (din_valid) begin
            hist_d = hist_shift;
            fill_d = fill_shift;
        end

        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    state_d = armed_next ? ARMED : FILLING;
                end
            end
            FILLING: begin
                if (din_valid && armed_next) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                state_d = ARMED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Non-overlapping mode starts collecting a fresh window after each hit.
        if (match && !overlap_q) begin
            fill_d  = '0;
            state_d = IDLE;
        end

        // Reconfiguration takes priority and discards any bit presented with it.
        if (cfg_we) begin
            pat_d     = cfg_pattern;
            len_d     = cfg_len_clamped;
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
            dout_d    = 1'b0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pat_q     <= DEFAULT_PATTERN;
            len_q     <= LEN_DEF_C;
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            dout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            dout_q    <= dout_d;
        end
    end

    assign dout = dout_q;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear beats a coincident match; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: streams, gaps, reconfiguration, length clamping and reset.
// Exercises the match counter too when SEQ_DETECT_MATCH_COUNT_EN is defined.
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_W   = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               din_valid = 1'b0;
    logic               din = 1'b0;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               dout;
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    logic               cnt_clear = 1'b0;
    logic [CNT_W-1:0]   match_count;
`endif

    int total = 0;
    int bad   = 0;

    seq_detect_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din_valid   (din_valid),
        .din         (din),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
`ifdef SEQ_DETECT_MATCH_COUNT_EN
        .cnt_clear   (cnt_clear),
        .match_count (match_count),
`endif
        .dout        (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[%0t] FAIL %s got=%0h exp=%0h", $time, tag, got, exp);
        end else begin
            $display("[%0t] ok   %s got=%0h", $time, tag, got);
        end
    endtask

    // One qualified (or idle) cycle, then dout is checked 1 time unit after the edge.
    task automatic step(input string tag, input logic v, input logic b, input logic exp_dout);
        din_valid = v;
        din       = b;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 1'b0;
        chk(tag, {31'd0, dout}, {31'd0, exp_dout});
    endtask

    // bits[i] is the i-th bit sent; exp[i] is dout expected right after it.
    task automatic run_stream(input string tag, input int n, input logic [15:0] bits,
                              input logic [15:0] exp);
        for (int i = 0; i < n; i++) begin
            step($sformatf("%s_b%0d", tag, i + 1), 1'b1, bits[i], exp[i]);
        end
    endtask

    // Presents a valid '1' alongside cfg_we to confirm configuration wins.
    task automatic do_cfg(input string tag, input logic [MAX_LEN-1:0] pat,
                          input logic [LEN_W-1:0] len, input logic ov);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        din_valid   = 1'b1;
        din         = 1'b1;
        @(posedge clk);
        #1;
        cfg_we    = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        chk(tag, {31'd0, dout}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", {31'd0, dout}, 32'd0);
`ifdef SEQ_DETECT_MATCH_COUNT_EN
        chk("reset_count", {30'd0, match_count}, 32'd0);
`endif
        reset = 1'b1;

        // Default 1101/len4 overlapping: pulses after bits 4 and 7
        run_stream("ovl", 7, 16'b1011011, 16'b1001000);

        // Reset asserted while dout is high clears it without a clock
        reset = 1'b0;
        #1;
        chk("rst_async", {31'd0, dout}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Non-overlapping: only the first pulse
        do_cfg("cfg_novl", 8'b0000_1101, 4'd4, 1'b0);
        run_stream("novl", 7, 16'b1011011, 16'b0001000);

        // Gaps of 3 idle cycles between valid bits
        do_cfg("cfg_gap", 8'b0000_1101, 4'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] gbits;
            gbits = 4'b1011;
            step($sformatf("gap_b%0d", i + 1), 1'b1, gbits[i], (i == 3));
            for (int k = 0; k < 3; k++) begin
                step($sformatf("gap_idle%0d_%0d", i + 1, k), 1'b0, 1'b1, 1'b0);
            end
        end

        // Three-bit pattern 101, overlapping
        do_cfg("cfg_101", 8'b0000_0101, 4'd3, 1'b1);
        run_stream("p101", 5, 16'b10101, 16'b10100);

        // cfg_len=0 behaves as len 1
        do_cfg("cfg_len0", 8'b0000_0001, 4'd0, 1'b1);
        run_stream("len0", 3, 16'b011, 16'b011);

        // cfg_len=15 clamps to 8: first pulse needs 8 bits
        do_cfg("cfg_len15", 8'hFF, 4'd15, 1'b1);
        run_stream("len15", 9, 16'b1_1111_1111, 16'b1_1000_0000);

        // Reset mid-stream drops partial history
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_stream("pre", 4, 16'b1011, 16'b1000);
        run_stream("pre2", 3, 16'b011, 16'b000);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_dout", {31'd0, dout}, 32'd0);
        reset = 1'b1;
        run_stream("post", 4, 16'b1011, 16'b1000);

`ifdef SEQ_DETECT_MATCH_COUNT_EN
        // Counter saturates at 3 with CNT_W=2; clear beats a coincident match
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        do_cfg("cfg_cnt", 8'b0000_0001, 4'd1, 1'b1);
        chk("cnt_after_cfg", {30'd0, match_count}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("cnt_b%0d", i + 1), 1'b1, 1'b1, 1'b1);
            chk($sformatf("cnt_val%0d", i + 1), {30'd0, match_count}, (i < 3) ? i + 1 : 3);
        end
        cnt_clear = 1'b1;
        step("cnt_clr_dout", 1'b1, 1'b1, 1'b1);
        cnt_clear = 1'b0;
        chk("cnt_cleared", {30'd0, match_count}, 32'd0);
        step("cnt_again", 1'b1, 1'b1, 1'b1);
        chk("cnt_again_val", {30'd0, match_count}, 32'd1);
        do_cfg("cfg_keep", 8'b0000_0001, 4'd1, 1'b1);
        chk("cnt_kept", {30'd0, match_count}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
